abc: RTL and testbench



---
 rtl/abc.sv | 149 ++++++++++++++
 tb/tb_abc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/abc.sv
// Perimeter calculator: captures sides a,b over a dav_/rfd handshake and holds p = 2*(a+b).
// Latency: p is written one edge after capture, or five edges after capture with ABC_SERIAL_EN.
// Backpressure: rfd stays low from capture until dav_ is seen high in ACK; no new capture while rfd is low.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-high
//   a, b       4-bit unsigned side lengths, sampled only on the IDLE capture edge
//   dav_       data available, active-low, held low by the producer until rfd falls
//   p          6-bit registered perimeter, written once per transaction
//   rfd        ready for data, registered
//
// Build option: define ABC_SERIAL_EN to compute A+B with a bit-serial adder,
// taking five CALC cycles instead of one. Results are identical in both builds.
module abc (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       dav_,
    output logic [5:0] p,
    output logic       rfd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [5:0] p_q, p_d;
    logic       rfd_q, rfd_d;
    logic       calc_done;

`ifdef ABC_SERIAL_EN
    // Serial adder state: bit index, ripple carry, and the sum bits shifted
    // in LSB first so that after four shifts acc_q[0] holds sum bit 0.
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       carry_q, carry_d;
    logic [3:0] acc_q, acc_d;
    logic       sum_bit;
    logic       op_a, op_b;

    assign op_a      = a_q[bit_cnt_q[1:0]];
    assign op_b      = b_q[bit_cnt_q[1:0]];
    assign sum_bit   = op_a ^ op_b ^ carry_q;
    // Bits 0..3 take four cycles; the fifth cycle folds the carry in as bit 4.
    assign calc_done = (bit_cnt_q == 3'd4);
`else
    logic [4:0] sum;

    assign sum       = {1'b0, a_q} + {1'b0, b_q};
    assign calc_done = 1'b1;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= 4'd0;
            b_q       <= 4'd0;
            p_q       <= 6'd0;
            rfd_q     <= 1'b1;
`ifdef ABC_SERIAL_EN
            bit_cnt_q <= 3'd0;
            carry_q   <= 1'b0;
            acc_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            p_q       <= p_d;
            rfd_q     <= rfd_d;
`ifdef ABC_SERIAL_EN
            bit_cnt_q <= bit_cnt_d;
            carry_q   <= carry_d;
            acc_q     <= acc_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!dav_)     state_d = CALC;
            CALC:    if (calc_done) state_d = ACK;
            ACK:     if (dav_)      state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        p_d       = p_q;
        rfd_d     = rfd_q;
`ifdef ABC_SERIAL_EN
        bit_cnt_d = bit_cnt_q;
        carry_d   = carry_q;
        acc_d     = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (!dav_) begin
                    a_d       = a;
                    b_d       = b;
                    rfd_d     = 1'b0;
`ifdef ABC_SERIAL_EN
                    bit_cnt_d = 3'd0;
                    carry_d   = 1'b0;
                    acc_d     = 4'd0;
`endif
                end
            end
            CALC: begin
`ifdef ABC_SERIAL_EN
                if (calc_done) begin
                    // Single write of the full result; p never shows partial sums.
                    p_d = {carry_q, acc_q, 1'b0};
                end else begin
                    acc_d     = {sum_bit, acc_q[3:1]};
                    carry_d   = (op_a & op_b) | (op_a & carry_q) | (op_b & carry_q);
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
`else
                p_d = {sum, 1'b0};
`endif
            end
            ACK: begin
                if (dav_) begin
                    rfd_d = 1'b1;
                end
            end
            default: begin
                rfd_d = 1'b1;
            end
        endcase
    end

    assign p   = p_q;
    assign rfd = rfd_q;

endmodule

// File: tb/tb_abc.sv
module tb_abc;

`ifdef ABC_SERIAL_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] a     = 4'd0;
    logic [3:0] b     = 4'd0;
    logic       dav_  = 1'b1;
    logic [5:0] p;
    logic       rfd;

    abc dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .dav_  (dav_),
        .p     (p),
        .rfd   (rfd)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a capture happens on the first edge that
    // sees dav_ low while idle; the result 2*(a+b) appears LAT edges later;
    // the handshake closes on the first edge after that which sees dav_ high.
    int m_edge = 0;
    int m_cap  = 0;
    int m_p    = 0;
    int m_pend = 0;
    bit m_busy = 1'b0;
    bit m_rfd  = 1'b1;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_rfd  = 1'b1;
            m_p    = 0;
            m_edge = 0;
        end else begin
            m_edge++;
            if (!m_busy) begin
                if (dav_ == 1'b0) begin
                    m_busy = 1'b1;
                    m_rfd  = 1'b0;
                    m_cap  = m_edge;
                    m_pend = 2 * (int'(a) + int'(b));
                end
            end else begin
                if (m_edge == m_cap + LAT) m_p = m_pend;
                if (m_edge > m_cap + LAT && dav_ == 1'b1) begin
                    m_busy = 1'b0;
                    m_rfd  = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    int         p_events = 0;
    logic [5:0] last_p   = 6'd0;

    always @(negedge clock) begin
        if (!reset) begin
            check("p_cycle", int'(p), m_p);
            check("rfd_cycle", int'(rfd), int'(m_rfd));
            if (p != last_p) p_events++;
        end
        last_p = p;
    end

    // Drive one transaction; report how many falling edges rfd took to fall
    // after dav_ went low and to rise after dav_ went high.
    task automatic txn(input logic [3:0] ta, input logic [3:0] tbv, input int hold,
                       output int fall_n, output int rise_n);
        int n;
        @(negedge clock);
        a    = ta;
        b    = tbv;
        dav_ = 1'b0;
        n    = 0;
        do begin
            @(negedge clock);
            n++;
        end while (rfd !== 1'b0 && n < 20);
        if (rfd !== 1'b0) check("rfd_fall_timeout", int'(rfd), 0);
        fall_n = n;
        a = 4'($urandom_range(15, 0));
        b = 4'($urandom_range(15, 0));
        repeat (hold) @(negedge clock);
        dav_ = 1'b1;
        n    = 0;
        do begin
            @(negedge clock);
            n++;
        end while (rfd !== 1'b1 && n < 20);
        if (rfd !== 1'b1) check("rfd_rise_timeout", int'(rfd), 1);
        rise_n = n;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int fn, rn, e0, evt_exp, prev_v, v;
        logic [3:0] sa, sb;

        // Reset
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_rfd", int'(rfd), 1);
        check("reset_p", int'(p), 0);

        // First transaction, long hold so rfd rise latency is measured from ACK
        txn(4'd3, 4'd1, LAT + 1, fn, rn);
        check("basic_p", int'(p), 8);
        check("basic_rfd_fall_cycles", fn, 1);
        check("basic_rfd_rise_cycles", rn, 1);

        // Sweep
        e0      = p_events;
        evt_exp = 0;
        prev_v  = 8;
        for (int i = 0; i < 32; i++) begin
            sa = 4'((i >> 1) + 3);
            sb = 4'(i + 1);
            v  = 2 * (int'(sa) + int'(sb));
            if (v != prev_v) evt_exp++;
            prev_v = v;
            txn(sa, sb, int'($urandom_range(6, 0)), fn, rn);
            check("sweep_p", int'(p), v);
            if (i == 15) check("sweep_i15_p", int'(p), 20);
        end
        check("sweep_p_events", p_events - e0, evt_exp);

        // Extremes
        txn(4'd15, 4'd15, 2, fn, rn);
        check("max_p", int'(p), 60);
        txn(4'd0, 4'd0, 0, fn, rn);
        check("zero_p", int'(p), 0);

        // Long dav_ hold after rfd falls
        e0 = p_events;
        txn(4'd7, 4'd2, 10 + LAT, fn, rn);
        check("hold_p", int'(p), 18);
        check("hold_p_events", p_events - e0, 1);
        check("hold_rfd_rise_cycles", rn, 1);

        // Reset during CALC
        @(negedge clock);
        a    = 4'd4;
        b    = 4'd4;
        dav_ = 1'b0;
        @(negedge clock);
        check("calc_rfd_low", int'(rfd), 0);
        reset = 1'b1;
        dav_  = 1'b1;
        #1;
        check("rst_calc_p", int'(p), 0);
        check("rst_calc_rfd", int'(rfd), 1);
        @(negedge clock);
        reset = 1'b0;

        txn(4'd5, 4'd2, 1, fn, rn);
        check("after_rst_p", int'(p), 14);

        // Reset during ACK with dav_ still low
        @(negedge clock);
        a    = 4'd6;
        b    = 4'd6;
        dav_ = 1'b0;
        repeat (LAT + 2) @(negedge clock);
        check("ack_p", int'(p), 24);
        reset = 1'b1;
        dav_  = 1'b1;
        #1;
        check("rst_ack_p", int'(p), 0);
        check("rst_ack_rfd", int'(rfd), 1);
        @(negedge clock);
        reset = 1'b0;

        txn(4'd5, 4'd2, 0, fn, rn);
        check("after_rst2_p", int'(p), 14);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
